rs_alu_station: RTL and testbench
=================================

Name: rs_alu_station

Overview:
- Reservation station directly upstream of the ALU.
- Accepts issued ALU/branch/jump µops from the dispatcher and holds them until both source operands are available.
- Captures operand values from the ALU and LSB result broadcasts.
- Each cycle it sends at most one ready µop, registered, to the ALU.

Parameters:
RS_SIZE, 16, number of entries (power of two, ≥2)
OPENUM_W, 6, opcode-enum width
ROB_POS_W, 5, ROB position tag width (including wrap bit)
DATA_W, 32, data/address width

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
rdy  in  1  global ready; when low, all state holds
clr  in  1  synchronous flush (mispredict)
dsp_to_rs_enable  in  1  issue valid
dsp_to_rs_openum  in  OPENUM_W  opcode
dsp_to_rs_rob_pos  in  ROB_POS_W  destination ROB tag
dsp_to_rs_rs1_ready  in  1  rs1 value valid
dsp_to_rs_rs1_val  in  DATA_W  rs1 value
dsp_to_rs_rs1_rob_pos  in  ROB_POS_W  rs1 producer tag when not ready
dsp_to_rs_rs2_ready / _rs2_val / _rs2_rob_pos  in  1/DATA_W/ROB_POS_W  same for rs2
dsp_to_rs_imm  in  DATA_W  immediate
dsp_to_rs_pc  in  DATA_W  instruction pc
rs_full  out  1  no free entry
alu_broadcast_enable / _rob_pos / _val  in  1/ROB_POS_W/DATA_W  ALU result bus
lsb_broadcast_enable / _rob_pos / _val  in  1/ROB_POS_W/DATA_W  LSB result bus
rs_to_alu_enable  out  1  µop valid this cycle
rs_to_alu_openum, _rob_pos, _rs1_val, _rs2_val, _imm, _pc  out  as above  µop fields

Behaviour:
- Storage per entry: busy, openum, rob_pos, rs1/rs2 {ready, val, tag}, imm, pc. A counter tracks the number of busy entries.
- Reset (rst_n low, async): all busy=0, count=0, rs_to_alu_enable=0, all rs_to_alu_* data=0.
- clr (sync, when rst_n high): same clearing as reset on the next edge. Clears regardless of rdy. Issue and broadcasts in that cycle are ignored.
- rdy low: no state or output register changes.
- rs_full = (count == RS_SIZE). It is combinational from registered state only.
- Issue while rs_full=1 is a protocol error and is dropped; no entry is altered.
- Issue writes to the lowest-index free entry.
- Issue-time forwarding: for each not-ready operand, if alu_broadcast_enable and its rob_pos equals the operand tag, store ready=1 with the ALU value. Otherwise apply the same check against the LSB bus. The ALU bus has priority if both match (the ROB guarantees unique tags).
- Wakeup: every busy entry with a not-ready operand whose tag matches an enabled broadcast sets ready=1 and captures the value at the edge. rs1 and rs2 are checked independently; both may wake in the same cycle.
- Select: combinational over registered state. Picks the lowest-index busy entry with both operands ready. Values captured this cycle are not visible to select until the next cycle.
- Dispatch at the edge: if an entry is selected, load rs_to_alu_* from it, set rs_to_alu_enable=1, and clear busy. Otherwise rs_to_alu_enable=0 and data outputs keep their previous values.
- Count update: count += issue_accepted − dispatched. Simultaneous issue and dispatch leaves count unchanged. A slot freed at edge k is reusable by issue in cycle k+1, not at edge k.
- Latency: a µop issued with both operands ready at edge k drives rs_to_alu_enable high in the cycle after edge k+1, provided no lower-index ready entry exists. A µop woken by a broadcast sampled at edge k is dispatched at edge k+1 at the earliest.
- Throughput: one dispatch per cycle. Non-selected ready entries wait; oldest-first ordering is not guaranteed.

Test Plan:
- Reset mid-operation: 3 busy entries, drop rst_n asynchronously between edges -> rs_to_alu_enable=0 immediately, rs_full=0, no dispatch after rst_n rises until a new issue.
- Ready issue: ADDI, rob_pos=3, rs1 ready val=5, imm=7 at edge 1 -> edge 2 outputs enable=1, rob_pos=3, rs1_val=5, imm=7. Enable=0 after edge 3.
- Wakeup: issue ADD rob_pos=4, rs1 tag=2 not ready, rs2 ready=1. ALU broadcasts rob_pos=2 val=0x10 at edge 3 -> dispatch at edge 4 with rs1_val=0x10. An LSB broadcast with tag 2 gives the same result.
- Issue-time forward: issue with rs2 tag=6 in the same cycle lsb_broadcast rob_pos=6 val=0xABCD -> entry is stored ready, dispatched the next edge with rs2_val=0xABCD.
- Full/simultaneous: fill 16 entries all waiting on tag 9 -> rs_full=1 and a further issue is dropped. Broadcast tag 9 -> entries dispatch one per cycle in index order 0..15. rs_full drops after the first dispatch edge, and an issue in that cycle lands in entry 0.
- Flush and rdy: with 5 busy entries, hold rdy=0 for 3 cycles -> outputs frozen. Then assert clr -> next edge count=0 and enable=0. A broadcast in the clr cycle wakes nothing.

Source files
------------

// File: rtl/rs_alu_station.sv
// rtl/rs_alu_station.sv - ALU reservation station: operand capture, broadcast wakeup, single-issue select
module rs_alu_station #(
    parameter int RS_SIZE   = 16,
    parameter int OPENUM_W  = 6,
    parameter int ROB_POS_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 dsp_to_rs_enable,
    input  logic [OPENUM_W-1:0]  dsp_to_rs_openum,
    input  logic [ROB_POS_W-1:0] dsp_to_rs_rob_pos,
    input  logic                 dsp_to_rs_rs1_ready,
    input  logic [DATA_W-1:0]    dsp_to_rs_rs1_val,
    input  logic [ROB_POS_W-1:0] dsp_to_rs_rs1_rob_pos,
    input  logic                 dsp_to_rs_rs2_ready,
    input  logic [DATA_W-1:0]    dsp_to_rs_rs2_val,
    input  logic [ROB_POS_W-1:0] dsp_to_rs_rs2_rob_pos,
    input  logic [DATA_W-1:0]    dsp_to_rs_imm,
    input  logic [DATA_W-1:0]    dsp_to_rs_pc,
    output logic                 rs_full,
    input  logic                 alu_broadcast_enable,
    input  logic [ROB_POS_W-1:0] alu_broadcast_rob_pos,
    input  logic [DATA_W-1:0]    alu_broadcast_val,
    input  logic                 lsb_broadcast_enable,
    input  logic [ROB_POS_W-1:0] lsb_broadcast_rob_pos,
    input  logic [DATA_W-1:0]    lsb_broadcast_val,
    output logic                 rs_to_alu_enable,
    output logic [OPENUM_W-1:0]  rs_to_alu_openum,
    output logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
    output logic [DATA_W-1:0]    rs_to_alu_rs1_val,
    output logic [DATA_W-1:0]    rs_to_alu_rs2_val,
    output logic [DATA_W-1:0]    rs_to_alu_imm,
    output logic [DATA_W-1:0]    rs_to_alu_pc
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]   r_busy;
    logic [CNT_W-1:0]     r_count;
    logic [OPENUM_W-1:0]  r_openum  [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rob_pos [RS_SIZE];
    logic [RS_SIZE-1:0]   r_rs1_ready;
    logic [RS_SIZE-1:0]   r_rs2_ready;
    logic [DATA_W-1:0]    r_rs1_val [RS_SIZE];
    logic [DATA_W-1:0]    r_rs2_val [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rs1_tag [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rs2_tag [RS_SIZE];
    logic [DATA_W-1:0]    r_imm     [RS_SIZE];
    logic [DATA_W-1:0]    r_pc      [RS_SIZE];

    logic                 w_issue;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_sel_found;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [RS_SIZE-1:0]   w_issue_mask;
    logic [RS_SIZE-1:0]   w_sel_mask;
    logic                 w_in_rs1_hit;
    logic                 w_in_rs2_hit;
    logic [DATA_W-1:0]    w_in_rs1_bus;
    logic [DATA_W-1:0]    w_in_rs2_bus;
    logic [RS_SIZE-1:0]   w_wake1;
    logic [RS_SIZE-1:0]   w_wake2;
    logic [DATA_W-1:0]    w_wake1_val [RS_SIZE];
    logic [DATA_W-1:0]    w_wake2_val [RS_SIZE];

    // {match, value} of the result buses against a tag; ALU bus wins a double match
    function automatic logic [DATA_W:0] f_snoop(input logic [ROB_POS_W-1:0] tag);
        if (alu_broadcast_enable && alu_broadcast_rob_pos == tag) return {1'b1, alu_broadcast_val};
        if (lsb_broadcast_enable && lsb_broadcast_rob_pos == tag) return {1'b1, lsb_broadcast_val};
        return {1'b0, {DATA_W{1'b0}}};
    endfunction

    assign rs_full      = (r_count == CNT_W'(RS_SIZE));
    assign w_issue      = dsp_to_rs_enable && !rs_full;
    assign w_issue_mask = RS_SIZE'(w_issue) << w_free_idx;
    assign w_sel_mask   = RS_SIZE'(w_sel_found) << w_sel_idx;

    // lowest free slot for issue and lowest fully-ready busy slot for dispatch
    always_comb begin
        w_free_idx  = '0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
            if (r_busy[i] && r_rs1_ready[i] && r_rs2_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // broadcast snoop for the incoming uop and for every stored operand tag
    always_comb begin
        {w_in_rs1_hit, w_in_rs1_bus} = f_snoop(dsp_to_rs_rs1_rob_pos);
        {w_in_rs2_hit, w_in_rs2_bus} = f_snoop(dsp_to_rs_rs2_rob_pos);
        for (int i = 0; i < RS_SIZE; i++) begin
            {w_wake1[i], w_wake1_val[i]} = f_snoop(r_rs1_tag[i]);
            {w_wake2[i], w_wake2_val[i]} = f_snoop(r_rs2_tag[i]);
        end
    end

    // entry payload: issue write into the free slot, wakeup capture in waiting slots
    always_ff @(posedge clk) begin
        if (rdy && !clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_issue_mask[i]) begin
                    r_openum[i]    <= dsp_to_rs_openum;
                    r_rob_pos[i]   <= dsp_to_rs_rob_pos;
                    r_imm[i]       <= dsp_to_rs_imm;
                    r_pc[i]        <= dsp_to_rs_pc;
                    r_rs1_tag[i]   <= dsp_to_rs_rs1_rob_pos;
                    r_rs2_tag[i]   <= dsp_to_rs_rs2_rob_pos;
                    r_rs1_ready[i] <= dsp_to_rs_rs1_ready || w_in_rs1_hit;
                    r_rs2_ready[i] <= dsp_to_rs_rs2_ready || w_in_rs2_hit;
                    r_rs1_val[i]   <= dsp_to_rs_rs1_ready ? dsp_to_rs_rs1_val : w_in_rs1_bus;
                    r_rs2_val[i]   <= dsp_to_rs_rs2_ready ? dsp_to_rs_rs2_val : w_in_rs2_bus;
                end else if (r_busy[i]) begin
                    if (!r_rs1_ready[i] && w_wake1[i]) begin
                        r_rs1_ready[i] <= 1'b1;
                        r_rs1_val[i]   <= w_wake1_val[i];
                    end
                    if (!r_rs2_ready[i] && w_wake2[i]) begin
                        r_rs2_ready[i] <= 1'b1;
                        r_rs2_val[i]   <= w_wake2_val[i];
                    end
                end
            end
        end
    end

    // occupancy: busy bits and the busy-entry counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_busy  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            r_busy  <= (r_busy | w_issue_mask) & ~w_sel_mask;
            r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_sel_found);
        end
    end

    // registered dispatch to the ALU; data holds when nothing is selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            rs_to_alu_enable  <= 1'b0;
            rs_to_alu_openum  <= '0;
            rs_to_alu_rob_pos <= '0;
            rs_to_alu_rs1_val <= '0;
            rs_to_alu_rs2_val <= '0;
            rs_to_alu_imm     <= '0;
            rs_to_alu_pc      <= '0;
        end else if (rdy) begin
            rs_to_alu_enable <= w_sel_found;
            if (w_sel_found) begin
                rs_to_alu_openum  <= r_openum[w_sel_idx];
                rs_to_alu_rob_pos <= r_rob_pos[w_sel_idx];
                rs_to_alu_rs1_val <= r_rs1_val[w_sel_idx];
                rs_to_alu_rs2_val <= r_rs2_val[w_sel_idx];
                rs_to_alu_imm     <= r_imm[w_sel_idx];
                rs_to_alu_pc      <= r_pc[w_sel_idx];
            end
        end
    end
endmodule

// File: tb/tb_rs_alu_station.sv
// tb/tb_rs_alu_station.sv - directed and randomized self-checking bench for rs_alu_station
module tb_rs_alu_station;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        dsp_en = 1'b0;
    logic [5:0]  dsp_op = '0;
    logic [4:0]  dsp_rob = '0;
    logic        dsp_r1rdy = 1'b0;
    logic [31:0] dsp_r1v = '0;
    logic [4:0]  dsp_r1t = '0;
    logic        dsp_r2rdy = 1'b0;
    logic [31:0] dsp_r2v = '0;
    logic [4:0]  dsp_r2t = '0;
    logic [31:0] dsp_imm = '0;
    logic [31:0] dsp_pc = '0;
    logic        alu_en = 1'b0;
    logic [4:0]  alu_rob = '0;
    logic [31:0] alu_val = '0;
    logic        lsb_en = 1'b0;
    logic [4:0]  lsb_rob = '0;
    logic [31:0] lsb_val = '0;
    logic        rs_full;
    logic        o_en;
    logic [5:0]  o_op;
    logic [4:0]  o_rob;
    logic [31:0] o_r1, o_r2, o_imm, o_pc;

    int n_vec = 0;
    int n_mis = 0;

    rs_alu_station dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
        .dsp_to_rs_enable(dsp_en), .dsp_to_rs_openum(dsp_op), .dsp_to_rs_rob_pos(dsp_rob),
        .dsp_to_rs_rs1_ready(dsp_r1rdy), .dsp_to_rs_rs1_val(dsp_r1v), .dsp_to_rs_rs1_rob_pos(dsp_r1t),
        .dsp_to_rs_rs2_ready(dsp_r2rdy), .dsp_to_rs_rs2_val(dsp_r2v), .dsp_to_rs_rs2_rob_pos(dsp_r2t),
        .dsp_to_rs_imm(dsp_imm), .dsp_to_rs_pc(dsp_pc), .rs_full(rs_full),
        .alu_broadcast_enable(alu_en), .alu_broadcast_rob_pos(alu_rob), .alu_broadcast_val(alu_val),
        .lsb_broadcast_enable(lsb_en), .lsb_broadcast_rob_pos(lsb_rob), .lsb_broadcast_val(lsb_val),
        .rs_to_alu_enable(o_en), .rs_to_alu_openum(o_op), .rs_to_alu_rob_pos(o_rob),
        .rs_to_alu_rs1_val(o_r1), .rs_to_alu_rs2_val(o_r2), .rs_to_alu_imm(o_imm), .rs_to_alu_pc(o_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [4:0]  rob;
        bit          r1rdy;
        logic [31:0] r1v;
        logic [4:0]  r1t;
        bit          r2rdy;
        logic [31:0] r2v;
        logic [4:0]  r2t;
        logic [31:0] imm;
        logic [31:0] pc;
    } ent_t;

    ent_t        m [N];
    logic        m_en = 1'b0;
    logic [5:0]  m_op = '0;
    logic [4:0]  m_rob = '0;
    logic [31:0] m_r1 = '0, m_r2 = '0, m_imm = '0, m_pc = '0;

    function automatic logic [32:0] bus_value(input logic [4:0] tag);
        if (alu_en && alu_rob == tag) return {1'b1, alu_val};
        if (lsb_en && lsb_rob == tag) return {1'b1, lsb_val};
        return 33'd0;
    endfunction

    function automatic logic model_full();
        int nb = 0;
        for (int i = 0; i < N; i++) nb += int'(m[i].busy);
        return nb == N;
    endfunction

    task automatic model_step();
        int sel = -1;
        int fr = -1;
        int nb = 0;
        logic [32:0] f;
        if (clr) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            m_en = 1'b0; m_op = '0; m_rob = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_pc = '0;
            return;
        end
        if (!rdy) return;
        for (int i = 0; i < N; i++) begin
            if (m[i].busy) nb++;
            if (sel < 0 && m[i].busy && m[i].r1rdy && m[i].r2rdy) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        m_en = (sel >= 0);
        if (sel >= 0) begin
            m_op = m[sel].op; m_rob = m[sel].rob; m_r1 = m[sel].r1v; m_r2 = m[sel].r2v;
            m_imm = m[sel].imm; m_pc = m[sel].pc;
            m[sel].busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (m[i].busy && !m[i].r1rdy) begin
                f = bus_value(m[i].r1t);
                if (f[32]) begin m[i].r1rdy = 1'b1; m[i].r1v = f[31:0]; end
            end
            if (m[i].busy && !m[i].r2rdy) begin
                f = bus_value(m[i].r2t);
                if (f[32]) begin m[i].r2rdy = 1'b1; m[i].r2v = f[31:0]; end
            end
        end
        if (dsp_en && nb < N) begin
            m[fr].busy = 1'b1; m[fr].op = dsp_op; m[fr].rob = dsp_rob;
            m[fr].imm = dsp_imm; m[fr].pc = dsp_pc; m[fr].r1t = dsp_r1t; m[fr].r2t = dsp_r2t;
            f = dsp_r1rdy ? {1'b1, dsp_r1v} : bus_value(dsp_r1t);
            m[fr].r1rdy = f[32]; m[fr].r1v = f[31:0];
            f = dsp_r2rdy ? {1'b1, dsp_r2v} : bus_value(dsp_r2t);
            m[fr].r2rdy = f[32]; m[fr].r2v = f[31:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        dsp_en = 1'b0; alu_en = 1'b0; lsb_en = 1'b0; clr = 1'b0; rdy = 1'b1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] rob,
                         input logic r1rdy, input logic [31:0] r1v, input logic [4:0] r1t,
                         input logic r2rdy, input logic [31:0] r2v, input logic [4:0] r2t,
                         input logic [31:0] imm, input logic [31:0] pc);
        dsp_en = 1'b1; dsp_op = op; dsp_rob = rob;
        dsp_r1rdy = r1rdy; dsp_r1v = r1v; dsp_r1t = r1t;
        dsp_r2rdy = r2rdy; dsp_r2v = r2v; dsp_r2t = r2t;
        dsp_imm = imm; dsp_pc = pc;
    endtask

    task automatic test_reset();
        quiet();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({o_en, rs_full} !== 2'b00) begin n_mis++; $display("FAIL reset_ctrl: got %b expected 00", {o_en, rs_full}); end
        n_vec++; if ({o_op, o_rob, o_r1, o_r2, o_imm, o_pc} !== '0) begin n_mis++; $display("FAIL reset_data: got %h expected 0", {o_op, o_rob, o_r1, o_r2, o_imm, o_pc}); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(6'h01, 5'(i + 1), 1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0, 32'd0, 32'd0);
            tick();
        end
        issue(6'h01, 5'd12, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 32'd0, 32'd0);
        tick(); quiet(); tick();
        n_vec++; if ({o_en, o_rob} !== {1'b1, 5'd12}) begin n_mis++; $display("FAIL reset_pre: got %h expected %h", {o_en, o_rob}, {1'b1, 5'd12}); end
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if ({o_en, rs_full, o_rob} !== 7'd0) begin n_mis++; $display("FAIL reset_async: got %h expected 0", {o_en, rs_full, o_rob}); end
        @(negedge clk); rst_n = 1'b1;
        alu_en = 1'b1; alu_rob = 5'd9; alu_val = 32'h5;
        tick(); quiet();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL reset_no_dispatch: got %b expected 0", o_en); end
        end
    endtask

    task automatic test_ready_issue();
        issue(6'h13, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd0, 5'd0, 32'd7, 32'h100);
        tick(); quiet();
        n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL ready_lat: got %b expected 0", o_en); end
        tick();
        n_vec++; if ({o_en, o_op, o_rob, o_r1, o_imm, o_pc} !== {1'b1, 6'h13, 5'd3, 32'd5, 32'd7, 32'h100}) begin
            n_mis++; $display("FAIL ready_dispatch: got %h expected %h", {o_en, o_op, o_rob, o_r1, o_imm, o_pc}, {1'b1, 6'h13, 5'd3, 32'd5, 32'd7, 32'h100});
        end
        tick();
        n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL ready_single: got %b expected 0", o_en); end
    endtask

    task automatic test_wakeup();
        for (int b = 0; b < 2; b++) begin
            issue(6'h01, 5'd4, 1'b0, 32'd0, 5'd2, 1'b1, 32'h3, 5'd0, 32'd0, 32'h200);
            tick(); quiet(); tick();
            n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL wake_wait bus%0d: got %b expected 0", b, o_en); end
            if (b == 0) begin alu_en = 1'b1; alu_rob = 5'd2; alu_val = 32'h10; end
            else begin lsb_en = 1'b1; lsb_rob = 5'd2; lsb_val = 32'h10; end
            tick(); quiet();
            n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL wake_early bus%0d: got %b expected 0", b, o_en); end
            tick();
            n_vec++; if ({o_en, o_rob, o_r1, o_r2} !== {1'b1, 5'd4, 32'h10, 32'h3}) begin
                n_mis++; $display("FAIL wake_dispatch bus%0d: got %h expected %h", b, {o_en, o_rob, o_r1, o_r2}, {1'b1, 5'd4, 32'h10, 32'h3});
            end
            tick();
        end
    endtask

    task automatic test_forward();
        issue(6'h02, 5'd8, 1'b1, 32'h1, 5'd0, 1'b0, 32'd0, 5'd6, 32'd0, 32'd0);
        lsb_en = 1'b1; lsb_rob = 5'd6; lsb_val = 32'hABCD;
        tick(); quiet(); tick();
        n_vec++; if ({o_en, o_rob, o_r1, o_r2} !== {1'b1, 5'd8, 32'h1, 32'hABCD}) begin
            n_mis++; $display("FAIL fwd_lsb: got %h expected %h", {o_en, o_rob, o_r1, o_r2}, {1'b1, 5'd8, 32'h1, 32'hABCD});
        end
        issue(6'h02, 5'd9, 1'b0, 32'd0, 5'd5, 1'b1, 32'h2, 5'd0, 32'd0, 32'd0);
        alu_en = 1'b1; alu_rob = 5'd5; alu_val = 32'h1111;
        lsb_en = 1'b1; lsb_rob = 5'd5; lsb_val = 32'h2222;
        tick(); quiet(); tick();
        n_vec++; if ({o_en, o_rob, o_r1} !== {1'b1, 5'd9, 32'h1111}) begin
            n_mis++; $display("FAIL fwd_alu_prio: got %h expected %h", {o_en, o_rob, o_r1}, {1'b1, 5'd9, 32'h1111});
        end
        tick();
    endtask

    task automatic test_flush_rdy();
        for (int i = 0; i < 5; i++) begin
            issue(6'h04, 5'(16 + i), 1'b0, 32'd0, 5'd11, 1'b1, 32'd0, 5'd0, 32'd0, 32'd0);
            tick();
        end
        issue(6'h04, 5'd7, 1'b1, 32'h55, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'd0);
        tick(); quiet(); tick();
        n_vec++; if ({o_en, o_rob} !== {1'b1, 5'd7}) begin n_mis++; $display("FAIL flush_pre: got %h expected %h", {o_en, o_rob}, {1'b1, 5'd7}); end
        rdy = 1'b0;
        issue(6'h04, 5'd30, 1'b1, 32'h1, 5'd0, 1'b1, 32'h1, 5'd0, 32'd0, 32'd0);
        alu_en = 1'b1; alu_rob = 5'd11; alu_val = 32'hEE;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if ({o_en, o_rob, o_r1, rs_full} !== {1'b1, 5'd7, 32'h55, 1'b0}) begin
                n_mis++; $display("FAIL rdy_hold: got %h expected %h", {o_en, o_rob, o_r1, rs_full}, {1'b1, 5'd7, 32'h55, 1'b0});
            end
        end
        quiet(); tick();
        n_vec++; if ({o_en, o_rob} !== {1'b0, 5'd7}) begin n_mis++; $display("FAIL rdy_no_capture: got %h expected %h", {o_en, o_rob}, {1'b0, 5'd7}); end
        clr = 1'b1; alu_en = 1'b1; alu_rob = 5'd11; alu_val = 32'hEE;
        tick(); quiet();
        n_vec++; if ({o_en, rs_full, o_rob, o_r1} !== '0) begin n_mis++; $display("FAIL flush_clear: got %h expected 0", {o_en, rs_full, o_rob, o_r1}); end
        alu_en = 1'b1; alu_rob = 5'd11; alu_val = 32'hEE;
        tick(); quiet();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL flush_empty: got %b expected 0", o_en); end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < N; i++) begin
            issue(6'h03, 5'(i), 1'b0, 32'd0, 5'd9, 1'b1, 32'(i), 5'd0, 32'd0, 32'd0);
            tick();
            if (i == N - 2) begin
                n_vec++; if (rs_full !== 1'b0) begin n_mis++; $display("FAIL full_15: got %b expected 0", rs_full); end
            end
        end
        n_vec++; if (rs_full !== 1'b1) begin n_mis++; $display("FAIL full_16: got %b expected 1", rs_full); end
        issue(6'h03, 5'd20, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'd0);
        tick(); quiet();
        n_vec++; if ({rs_full, o_en} !== 2'b10) begin n_mis++; $display("FAIL full_drop: got %b expected 10", {rs_full, o_en}); end
        alu_en = 1'b1; alu_rob = 5'd9; alu_val = 32'h99;
        tick(); quiet();
        n_vec++; if ({rs_full, o_en} !== 2'b10) begin n_mis++; $display("FAIL full_wake: got %b expected 10", {rs_full, o_en}); end
        tick();
        n_vec++; if ({o_en, o_rob, o_r1, rs_full} !== {1'b1, 5'd0, 32'h99, 1'b0}) begin
            n_mis++; $display("FAIL full_first: got %h expected %h", {o_en, o_rob, o_r1, rs_full}, {1'b1, 5'd0, 32'h99, 1'b0});
        end
        issue(6'h03, 5'd21, 1'b1, 32'h77, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'd0);
        tick(); quiet();
        n_vec++; if ({o_en, o_rob} !== {1'b1, 5'd1}) begin n_mis++; $display("FAIL full_second: got %h expected %h", {o_en, o_rob}, {1'b1, 5'd1}); end
        for (int k = 0; k < N - 1; k++) begin
            logic [4:0] exp_rob;
            exp_rob = (k == 0) ? 5'd21 : 5'(k + 1);
            tick();
            n_vec++; if ({o_en, o_rob} !== {1'b1, exp_rob}) begin
                n_mis++; $display("FAIL full_order step%0d: got %h expected %h", k, {o_en, o_rob}, {1'b1, exp_rob});
            end
        end
        tick();
        n_vec++; if (o_en !== 1'b0) begin n_mis++; $display("FAIL full_drain: got %b expected 0", o_en); end
    endtask

    task automatic test_random();
        logic [140:0] act, exp;
        for (int c = 0; c < 800; c++) begin
            rdy = ($urandom_range(7) != 0);
            clr = (c == 0) || ($urandom_range(149) == 0);
            dsp_en = ($urandom_range(3) != 0);
            dsp_op = 6'($urandom); dsp_rob = 5'($urandom);
            dsp_r1rdy = ($urandom_range(2) == 0); dsp_r1v = $urandom; dsp_r1t = 5'($urandom_range(7));
            dsp_r2rdy = ($urandom_range(2) == 0); dsp_r2v = $urandom; dsp_r2t = 5'($urandom_range(7));
            dsp_imm = $urandom; dsp_pc = $urandom;
            alu_en = ($urandom_range(2) == 0); alu_rob = 5'($urandom_range(7)); alu_val = $urandom;
            lsb_en = ($urandom_range(2) == 0); lsb_rob = 5'($urandom_range(7)); lsb_val = $urandom;
            @(posedge clk);
            model_step();
            #1;
            act = {o_en, rs_full, o_op, o_rob, o_r1, o_r2, o_imm, o_pc};
            exp = {m_en, model_full(), m_op, m_rob, m_r1, m_r2, m_imm, m_pc};
            n_vec++; if (act !== exp) begin n_mis++; $display("FAIL random cycle%0d: got %h expected %h", c, act, exp); end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_forward();
        test_flush_rdy();
        test_full();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
